// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: request FIFO, rounding-mode resolution, start/done unit driver with timeout, tagged response and sticky fflags
// Ports: clk/rst (async active-low); req_* request channel (valid/ready);
// csr_frm dynamic rounding mode; flags_clr clears fflags;
// ex_* execution port (level start, done, abort pulse); rsp_* response channel (valid/ready); fflags sticky CSR flags.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_c,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       csr_frm,
  input  logic             flags_clr,
  output logic             ex_start,
  output logic             ex_abort,
  output logic [4:0]       ex_op,
  output logic [2:0]       ex_rm,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_c,
  input  logic             ex_done,
  input  logic [31:0]      ex_result,
  input  logic [4:0]       ex_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       rsp_flags,
  output logic [1:0]       rsp_err,
  output logic [4:0]       fflags
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 5 + 3 + 96 + TAG_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [TAG_W-1:0] tag_q;
  logic [4:0]       h_op;
  logic [2:0]       h_rm, rm_r;
  logic [31:0]      h_a, h_b, h_c;
  logic [TAG_W-1:0] h_tag;
  logic             push, pop, rm_bad, tmo, hs;
  assign {h_op, h_rm, h_a, h_b, h_c, h_tag} = mem[rp];
  assign rm_r      = (h_rm == 3'b111) ? csr_frm : h_rm;
  // 101, 110 and 111 are reserved once dynamic mode is resolved
  assign rm_bad    = rm_r[2] & (rm_r[1] | rm_r[0]);
  // gated by rst so the port reads 0 while reset is held
  assign req_ready = rst && (count < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign tmo       = timer == TW'(TIMEOUT - 1);
  assign ex_start  = state == EXEC;
  // decoded from state only, so it cannot see a same-cycle ex_done
  assign ex_abort  = ex_start && tmo;
  assign rsp_valid = state == RESP;
  assign hs        = rsp_valid && rsp_ready;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {req_op, req_rm, req_a, req_b, req_c, req_tag};
  always_ff @(posedge clk or negedge rst)
    if (!rst) fflags <= '0;
    else      fflags <= (flags_clr ? 5'b0 : fflags) | (hs ? rsp_flags : 5'b0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      state      <= IDLE;
      timer      <= '0;
      tag_q      <= '0;
      ex_op      <= '0;
      ex_rm      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_c       <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_flags  <= '0;
      rsp_err    <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        ex_op <= h_op;
        ex_rm <= rm_r;
        ex_a  <= h_a;
        ex_b  <= h_b;
        ex_c  <= h_c;
        tag_q <= h_tag;
        timer <= '0;
        if (rm_bad) begin
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= 2'b01;
          rsp_tag    <= h_tag;
          state      <= RESP;
        end else
          state <= EXEC;
      end
      if (state == EXEC) begin
        timer <= timer + TW'(1);
        if (ex_done) begin
          rsp_result <= ex_result;
          rsp_flags  <= ex_flags;
          rsp_err    <= 2'b00;
          rsp_tag    <= tag_q;
          state      <= RESP;
        end else if (tmo) begin
          rsp_result <= 32'h7FC00000;
          rsp_flags  <= 5'b10000;
          rsp_err    <= 2'b10;
          rsp_tag    <= tag_q;
          state      <= RESP;
        end
      end
      if (hs) state <= IDLE;
    end
endmodule
